// File: rtl/reg_rename_file.sv
// reg_rename_file: architectural register file with per-register rename state.
// Holds 32 x 32-bit values plus a busy bit and ROB tag per register, with
// commit writes, dispatch renames, flush, and two combinational read ports.
// x0 is hardwired to zero and never renamed.
// Optional feature: define REG_COMMIT_BYPASS_EN to forward a same-cycle
// matching commit onto the read ports.
module reg_rename_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        register_update_flag,
    input  logic [4:0]  register_commit_dest,
    input  logic [31:0] register_value,
    input  logic [3:0]  rename_sent_to_register,
    input  logic        issue_flag,
    input  logic [4:0]  issue_dest,
    input  logic [3:0]  issue_rename,
    input  logic        flush,
    input  logic [4:0]  rs1_idx,
    input  logic [4:0]  rs2_idx,
    output logic [31:0] rs1_value,
    output logic [31:0] rs2_value,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic [3:0]  rs1_rename,
    output logic [3:0]  rs2_rename
);

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned IDX_W    = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned TAG_W    = 4;

    logic [DATA_W-1:0] value_q [NUM_REGS];
    logic [DATA_W-1:0] value_d [NUM_REGS];
    logic [TAG_W-1:0]  tag_q   [NUM_REGS];
    logic [TAG_W-1:0]  tag_d   [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    logic commit_v_c;
    logic issue_v_c;

    // Qualified commit and issue requests; x0 targets are dropped here.
    always_comb begin
        commit_v_c = rdy && register_update_flag && (register_commit_dest != '0);
        issue_v_c  = rdy && issue_flag && (issue_dest != '0) && !flush;
    end

    // Next-state for every register: commit value, busy/tag update, flush.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            value_d[i] = value_q[i];
            tag_d[i]   = tag_q[i];
            busy_d[i]  = busy_q[i];
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            if (commit_v_c && (register_commit_dest == IDX_W'(i))) begin
                value_d[i] = register_value;
                // A newer producer issued this cycle keeps the register busy.
                if ((tag_q[i] == rename_sent_to_register) &&
                    !(issue_v_c && (issue_dest == IDX_W'(i)))) begin
                    busy_d[i] = 1'b0;
                end
            end
            if (issue_v_c && (issue_dest == IDX_W'(i))) begin
                busy_d[i] = 1'b1;
                tag_d[i]  = issue_rename;
            end
            if (rdy && flush) begin
                busy_d[i] = 1'b0;
                tag_d[i]  = '0;
            end
        end
        // x0 holds constant zero state.
        value_d[0] = '0;
        tag_d[0]   = '0;
        busy_d[0]  = 1'b0;
    end

    // State registers; rdy low freezes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q <= '0;
        end else if (rdy) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                value_q[i] <= value_d[i];
                tag_q[i]   <= tag_d[i];
            end
            busy_q <= busy_d;
        end
    end

    // True when a same-cycle commit retires the current producer of idx.
    function automatic logic commit_hit(input logic [IDX_W-1:0] idx);
        return commit_v_c && busy_q[idx] && (register_commit_dest == idx) &&
               (tag_q[idx] == rename_sent_to_register);
    endfunction

    logic rs1_hit_c;
    logic rs2_hit_c;

    // Bypass match per read port; tied off when forwarding is not built in.
    always_comb begin
`ifdef REG_COMMIT_BYPASS_EN
        rs1_hit_c = commit_hit(rs1_idx);
        rs2_hit_c = commit_hit(rs2_idx);
`else
        rs1_hit_c = 1'b0;
        rs2_hit_c = 1'b0;
`endif
    end

    // Read port 1: zero in reset and for x0, forwarded value on a commit hit.
    always_comb begin
        rs1_value  = '0;
        rs1_busy   = 1'b0;
        rs1_rename = '0;
        if (rst && (rs1_idx != '0)) begin
            if (rs1_hit_c) begin
                rs1_value = register_value;
            end else begin
                rs1_value  = value_q[rs1_idx];
                rs1_busy   = busy_q[rs1_idx];
                rs1_rename = busy_q[rs1_idx] ? tag_q[rs1_idx] : '0;
            end
        end
    end

    // Read port 2: same behaviour as read port 1.
    always_comb begin
        rs2_value  = '0;
        rs2_busy   = 1'b0;
        rs2_rename = '0;
        if (rst && (rs2_idx != '0)) begin
            if (rs2_hit_c) begin
                rs2_value = register_value;
            end else begin
                rs2_value  = value_q[rs2_idx];
                rs2_busy   = busy_q[rs2_idx];
                rs2_rename = busy_q[rs2_idx] ? tag_q[rs2_idx] : '0;
            end
        end
    end

    // Without forwarding the helper is unreferenced; keep it visible to lint.
`ifndef REG_COMMIT_BYPASS_EN
    logic unused_hit_c;
    always_comb unused_hit_c = commit_hit('0);
`endif

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed bench for reg_rename_file. Inputs change 1ns after a rising edge;
// outputs are compared mid-cycle, before the next rising edge.
module tb_reg_rename_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        register_update_flag;
    logic [4:0]  register_commit_dest;
    logic [31:0] register_value;
    logic [3:0]  rename_sent_to_register;
    logic        issue_flag;
    logic [4:0]  issue_dest;
    logic [3:0]  issue_rename;
    logic        flush;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [3:0]  rs1_rename;
    logic [3:0]  rs2_rename;

    int n_checks = 0;
    int n_fails  = 0;

    reg_rename_file dut (
        .clk                     (clk),
        .rst                     (rst),
        .rdy                     (rdy),
        .register_update_flag    (register_update_flag),
        .register_commit_dest    (register_commit_dest),
        .register_value          (register_value),
        .rename_sent_to_register (rename_sent_to_register),
        .issue_flag              (issue_flag),
        .issue_dest              (issue_dest),
        .issue_rename            (issue_rename),
        .flush                   (flush),
        .rs1_idx                 (rs1_idx),
        .rs2_idx                 (rs2_idx),
        .rs1_value               (rs1_value),
        .rs2_value               (rs2_value),
        .rs1_busy                (rs1_busy),
        .rs2_busy                (rs2_busy),
        .rs1_rename              (rs1_rename),
        .rs2_rename              (rs2_rename)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Check read port 1 (value, busy, tag) after presenting idx.
    task automatic chk1(input string name, input logic [4:0] idx,
                        input logic [31:0] v, input logic b, input logic [3:0] t);
        rs1_idx = idx;
        #1;
        chk({name, ".val"},  rs1_value,         v);
        chk({name, ".busy"}, 32'(rs1_busy),     32'(b));
        chk({name, ".tag"},  32'(rs1_rename),   32'(t));
    endtask

    task automatic chk2(input string name, input logic [4:0] idx,
                        input logic [31:0] v, input logic b, input logic [3:0] t);
        rs2_idx = idx;
        #1;
        chk({name, ".val"},  rs2_value,         v);
        chk({name, ".busy"}, 32'(rs2_busy),     32'(b));
        chk({name, ".tag"},  32'(rs2_rename),   32'(t));
    endtask

    task automatic idle();
        rdy = 1'b1;
        register_update_flag = 1'b0;
        register_commit_dest = '0;
        register_value = '0;
        rename_sent_to_register = '0;
        issue_flag = 1'b0;
        issue_dest = '0;
        issue_rename = '0;
        flush = 1'b0;
    endtask

    // Apply the driven request at the next rising edge, then clear requests.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_issue(input logic [4:0] d, input logic [3:0] t);
        issue_flag = 1'b1; issue_dest = d; issue_rename = t;
    endtask

    task automatic do_commit(input logic [4:0] d, input logic [3:0] t, input logic [31:0] v);
        register_update_flag = 1'b1; register_commit_dest = d;
        rename_sent_to_register = t; register_value = v;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        rs1_idx = 5'd5;
        rs2_idx = 5'd0;
        #3;
        chk1("reset_x5", 5'd5, 32'h0, 1'b0, 4'h0);

        // Release reset away from a clock edge.
        #9 rst = 1'b1;
        tick();

        // x0 ignores renames and writes.
        do_issue(5'd0, 4'd3);
        do_commit(5'd0, 4'd3, 32'hFFFF_FFFF);
        tick();
        chk1("x0_after_issue", 5'd0, 32'h0, 1'b0, 4'h0);
        chk2("x5_idle", 5'd5, 32'h0, 1'b0, 4'h0);

        // Issue then matching commit.
        do_issue(5'd5, 4'd2);
        tick();
        chk1("x5_issued", 5'd5, 32'h0, 1'b1, 4'd2);
        do_commit(5'd5, 4'd2, 32'h1234);
        tick();
        chk1("x5_committed", 5'd5, 32'h1234, 1'b0, 4'h0);

        // Stale commit after re-rename keeps the newer producer.
        do_issue(5'd5, 4'd2);
        tick();
        do_issue(5'd5, 4'd7);
        tick();
        do_commit(5'd5, 4'd2, 32'hAA);
        tick();
        chk1("x5_stale_commit", 5'd5, 32'hAA, 1'b1, 4'd7);

        // Same-cycle commit and issue on x6.
        do_commit(5'd6, 4'd4, 32'h66);
        do_issue(5'd6, 4'd9);
        tick();
        chk2("x6_commit_issue", 5'd6, 32'h66, 1'b1, 4'd9);

        // Busy x6 with matching tag but same-cycle newer issue stays busy.
        do_commit(5'd6, 4'd9, 32'h67);
        do_issue(5'd6, 4'd1);
        tick();
        chk2("x6_match_plus_issue", 5'd6, 32'h67, 1'b1, 4'd1);

        // Flush with concurrent issue and commit.
        do_issue(5'd1, 4'd1); tick();
        do_issue(5'd2, 4'd2); tick();
        do_issue(5'd3, 4'd3); tick();
        chk1("x2_busy_pre_flush", 5'd2, 32'h0, 1'b1, 4'd2);
        flush = 1'b1;
        do_issue(5'd4, 4'd5);
        do_commit(5'd1, 4'd0, 32'h11);
        tick();
        chk1("x1_flush", 5'd1, 32'h11, 1'b0, 4'h0);
        chk2("x3_flush", 5'd3, 32'h0, 1'b0, 4'h0);
        chk1("x4_not_renamed", 5'd4, 32'h0, 1'b0, 4'h0);
        chk2("x5_flush", 5'd5, 32'hAA, 1'b0, 4'h0);

        // rdy low holds all state.
        rdy = 1'b0;
        do_issue(5'd8, 4'd3);
        do_commit(5'd5, 4'd0, 32'hDEAD);
        @(posedge clk);
        #1;
        chk1("x8_hold", 5'd8, 32'h0, 1'b0, 4'h0);
        chk2("x5_hold", 5'd5, 32'hAA, 1'b0, 4'h0);
        idle();

        // Tag 0 is a legal producer tag.
        do_issue(5'd9, 4'd0);
        tick();
        chk1("x9_tag0_busy", 5'd9, 32'h0, 1'b1, 4'd0);
        do_commit(5'd9, 4'd0, 32'h99);
        tick();
        chk1("x9_tag0_commit", 5'd9, 32'h99, 1'b0, 4'd0);

        // Mismatched tag writes value but stays busy.
        do_issue(5'd10, 4'd4);
        tick();
        do_commit(5'd10, 4'd3, 32'h1);
        tick();
        chk2("x10_mismatch", 5'd10, 32'h1, 1'b1, 4'd4);

        // Same-cycle commit visibility on the read port.
        do_issue(5'd7, 4'd5);
        tick();
        do_commit(5'd7, 4'd5, 32'h55);
`ifdef REG_COMMIT_BYPASS_EN
        chk1("x7_bypass", 5'd7, 32'h55, 1'b0, 4'h0);
`else
        chk1("x7_no_bypass", 5'd7, 32'h0, 1'b1, 4'd5);
`endif
        tick();
        chk1("x7_next_cycle", 5'd7, 32'h55, 1'b0, 4'h0);

        // Asynchronous reset mid-cycle clears state and outputs immediately.
        do_issue(5'd1, 4'd6);
        do_commit(5'd6, 4'd1, 32'h77);
        rst = 1'b0;
        #1;
        chk1("async_rst_x7", 5'd7, 32'h0, 1'b0, 4'h0);
        chk2("async_rst_x6", 5'd6, 32'h0, 1'b0, 4'h0);
        idle();
        @(posedge clk);
        #2 rst = 1'b1;
        tick();
        chk1("post_rst_x1", 5'd1, 32'h0, 1'b0, 4'h0);
        chk2("post_rst_x10", 5'd10, 32'h0, 1'b0, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
